pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Merges the load-use stall from the hazard detection unit, taken-branch redirects, multi-cycle MUL/DIV (MDU) occupancy and data-memory wait states into one consistent set of per-register enable and flush controls. It also handles the MDU start/abort handshake and keeps saturating stall and flush performance counters. Sits in the top level between the ID/EX/MEM control logic and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- MDU_TIMEOUT, 64: max cycles in S_MDU before forced abort (≥2).
- CNT_W, 32: width of each performance counter.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load_hazard  in  1  load in EX with a dependent instruction in ID.
- branch_taken  in  1  EX-stage branch/jump redirect.
- mdu_req  in  1  EX holds an MDU op.
- mdu_done  in  1  one-cycle MDU result-valid pulse.
- dmem_req  in  1  MEM-stage load/store active.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register/PC load enables.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble (NOP) into that register.
- mdu_start  out  1  one-cycle MDU launch pulse.
- mdu_abort  out  1  one-cycle MDU kill pulse on timeout.
- timeout_err  out  1  sticky; set on any MDU timeout.
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating.
- flush_cnt  out  CNT_W  taken-branch flushes, saturating.

## Operation
- States: S_RUN, S_MDU, S_MEM. Registers: mdu_cyc (wide enough for MDU_TIMEOUT-1), done_pend, timeout_err, both counters.
- Default each cycle: all enables 1, all flushes 0, pulses 0.
- mem_stall = dmem_req & ~dmem_ready. It freezes PC, IF/ID, ID/EX and EX/MEM, and sets mem_wb_flush.
- S_RUN priority, highest first:
  - mem_stall: apply the mem_stall freeze and go to S_MEM.
  - mdu_req: mdu_start=1; freeze PC, IF/ID and ID/EX; ex_mem_flush=1; clear mdu_cyc; go to S_MDU.
  - branch_taken: if_id_flush=1 and id_ex_flush=1; flush_cnt++.
  - load_hazard: freeze PC and IF/ID; id_ex_flush=1.
- S_MDU: PC, IF/ID and ID/EX are always frozen; mdu_cyc++ each cycle.
  - mdu_done: set done_pend.
  - mem_stall: also set ex_mem_en=0 and mem_wb_flush=1.
  - Otherwise ex_mem_flush=1 (bubbles).
  - Exit when (done_pend | mdu_done) & ~mem_stall: all enables 1 (EX result advances), clear done_pend, go to S_RUN.
  - Timeout when mdu_cyc == MDU_TIMEOUT-1 without done: mdu_abort=1, set timeout_err, treat as done (same exit rule).
- S_MEM: mem_stall freeze holds while dmem_ready=0. The cycle dmem_ready=1: all enables 1, go to S_RUN. branch_taken and load_hazard are ignored in S_MEM; they are re-evaluated in S_RUN.
- Counters saturate at all-ones: no wrap at 2^CNT_W-1.

## Timing
- Enable and flush outputs are combinational from state and inputs, valid in the same cycle. State, counters and flags update on the rising edge.
- Reset (cycle-synchronous, mid-operation allowed):
  - state=S_RUN; mdu_cyc, done_pend, timeout_err and both counters = 0.
  - While reset=1: all enables 1, all flushes 1, mdu_start=0, mdu_abort=0.
- Load-use stall: exactly 1 cycle per load_hazard assertion, assuming the hazard unit deasserts once the bubble is inserted.
- MDU op latency = N+1 cycles in EX when mdu_done arrives N cycles after mdu_start. The timeout path takes MDU_TIMEOUT cycles.
- mdu_start fires once per MDU op. It never re-fires while in S_MDU, even with mdu_req held high.
- mdu_done arriving during S_RUN or S_MEM is ignored.
- Simultaneous branch_taken and load_hazard in S_RUN: branch wins; no stall, flush only.

## Test plan
- Load-use: load_hazard=1 for 1 cycle in S_RUN -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cnt=1.
- Branch: branch_taken=1 -> if_id_flush=id_ex_flush=1 for 1 cycle; flush_cnt=1; pc_en stays 1. Assert load_hazard with it -> identical result.
- MDU: mdu_req=1, mdu_done 5 cycles after mdu_start -> mdu_start pulses once; 5 frozen cycles with ex_mem_flush=1, then ex_mem_en=1 with state S_RUN; stall_cnt=5.
- MDU plus memory: mem_stall held for 3 cycles overlapping mdu_done -> done_pend set; exit occurs on the cycle dmem_ready=1; no result is lost.
- Timeout at MDU_TIMEOUT=8 with no mdu_done -> mdu_abort pulses at cycle 8 of the op; timeout_err=1 and stays 1 until reset; pipeline resumes.
- Reset in S_MDU mid-op, plus counter saturation (CNT_W=4, 20 stalls) -> state S_RUN, no mdu_start after reset; stall_cnt holds at 15.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges load-use, branch, MDU and
// data-memory wait conditions into per-register enables/flushes, plus perf counters.
module pipeline_stall_controller #(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_hazard,
    input  logic             branch_taken,
    input  logic             mdu_req,
    input  logic             mdu_done,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mdu_start,
    output logic             mdu_abort,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned CycW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [CycW-1:0] CycLast = CycW'(MDU_TIMEOUT - 1);

    typedef enum logic [1:0] {S_RUN, S_MDU, S_MEM} state_t;

    state_t            r_state, w_state_d;
    logic [CycW-1:0]   r_mdu_cyc, w_mdu_cyc_d;
    logic              r_done_pend, w_done_pend_d;
    logic              r_timeout_err;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

    logic w_mem_stall;
    logic w_timeout;
    logic w_done;
    logic w_branch_flush;

    assign w_mem_stall = dmem_req & ~dmem_ready;
    assign w_timeout   = (r_state == S_MDU) && (r_mdu_cyc == CycLast) && !r_done_pend && !mdu_done;
    assign w_done      = r_done_pend | mdu_done | w_timeout;

    always_comb begin
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        id_ex_en       = 1'b1;
        ex_mem_en      = 1'b1;
        mem_wb_en      = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        mem_wb_flush   = 1'b0;
        mdu_start      = 1'b0;
        mdu_abort      = 1'b0;
        w_branch_flush = 1'b0;
        w_state_d      = r_state;
        w_mdu_cyc_d    = r_mdu_cyc;
        w_done_pend_d  = r_done_pend;

        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mem_stall) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_en    = 1'b0;
                        mem_wb_flush = 1'b1;
                        w_state_d    = S_MEM;
                    end else if (mdu_req) begin
                        mdu_start     = 1'b1;
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_flush  = 1'b1;
                        w_mdu_cyc_d   = '0;
                        w_done_pend_d = 1'b0;
                        w_state_d     = S_MDU;
                    end else if (branch_taken) begin
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                        w_branch_flush = 1'b1;
                    end else if (load_hazard) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                S_MDU: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    if (r_mdu_cyc != CycLast) begin
                        w_mdu_cyc_d = r_mdu_cyc + CycW'(1);
                    end
                    // A timeout behaves like a done: latched so a blocked exit still happens later
                    if (mdu_done || w_timeout) begin
                        w_done_pend_d = 1'b1;
                    end
                    mdu_abort = w_timeout;
                    if (w_done && !w_mem_stall) begin
                        pc_en         = 1'b1;
                        if_id_en      = 1'b1;
                        id_ex_en      = 1'b1;
                        w_done_pend_d = 1'b0;
                        w_state_d     = S_RUN;
                    end else if (w_mem_stall) begin
                        ex_mem_en    = 1'b0;
                        mem_wb_flush = 1'b1;
                    end else begin
                        ex_mem_flush = 1'b1;
                    end
                end
                S_MEM: begin
                    if (w_mem_stall) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_en    = 1'b0;
                        mem_wb_flush = 1'b1;
                    end else begin
                        w_state_d = S_RUN;
                    end
                end
                default: w_state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_RUN;
            r_mdu_cyc     <= '0;
            r_done_pend   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_state       <= w_state_d;
            r_mdu_cyc     <= w_mdu_cyc_d;
            r_done_pend   <= w_done_pend_d;
            r_timeout_err <= r_timeout_err | mdu_abort;
            if (!pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_branch_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign timeout_err = r_timeout_err;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller (MDU_TIMEOUT=8, CNT_W=4).
module tb_pipeline_stall_controller;

    localparam int unsigned MduTimeout = 8;
    localparam int unsigned CntW       = 4;

    logic clk = 1'b0;
    logic reset, load_hazard, branch_taken, mdu_req, mdu_done, dmem_req, dmem_ready;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic mdu_start, mdu_abort, timeout_err;
    logic [CntW-1:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .MDU_TIMEOUT(MduTimeout),
        .CNT_W      (CntW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_hazard (load_hazard),
        .branch_taken(branch_taken),
        .mdu_req     (mdu_req),
        .mdu_done    (mdu_done),
        .dmem_req    (dmem_req),
        .dmem_ready  (dmem_ready),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .id_ex_en    (id_ex_en),
        .ex_mem_en   (ex_mem_en),
        .mem_wb_en   (mem_wb_en),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush),
        .mdu_start   (mdu_start),
        .mdu_abort   (mdu_abort),
        .timeout_err (timeout_err),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb} and {if_id, id_ex, ex_mem, mem_wb}
    logic [4:0] en_vec;
    logic [3:0] fl_vec;
    assign en_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign fl_vec = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs are sampled 1ns later.
    task automatic cyc(input logic rst, input logic lh, input logic br, input logic mr,
                       input logic md, input logic dreq, input logic drdy);
        @(negedge clk);
        reset        = rst;
        load_hazard  = lh;
        branch_taken = br;
        mdu_req      = mr;
        mdu_done     = md;
        dmem_req     = dreq;
        dmem_ready   = drdy;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_en", 32'(en_vec), 32'h1f);
        check("rst_fl", 32'(fl_vec), 32'hf);
        check("rst_pulses", {30'd0, mdu_start, mdu_abort}, 32'd0);
        idle();
    endtask

    initial begin
        reset = 1'b1; load_hazard = 1'b0; branch_taken = 1'b0; mdu_req = 1'b0;
        mdu_done = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;

        // Reset state
        do_reset();
        check("idle_en", 32'(en_vec), 32'h1f);
        check("idle_fl", 32'(fl_vec), 32'h0);
        check("idle_stall_cnt", 32'(stall_cnt), 32'd0);
        check("idle_flush_cnt", 32'(flush_cnt), 32'd0);
        check("idle_terr", 32'(timeout_err), 32'd0);

        // Load-use stall: one cycle
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_en", 32'(en_vec), 32'h07);
        check("lu_fl", 32'(fl_vec), 32'h4);
        idle();
        check("lu_after_en", 32'(en_vec), 32'h1f);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // Branch alone, then branch with load_hazard: branch wins
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("br_en", 32'(en_vec), 32'h1f);
        check("br_fl", 32'(fl_vec), 32'hc);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("brlu_en", 32'(en_vec), 32'h1f);
        check("brlu_fl", 32'(fl_vec), 32'hc);
        check("br_flush_cnt1", 32'(flush_cnt), 32'd1);
        idle();
        check("br_flush_cnt2", 32'(flush_cnt), 32'd2);
        check("br_stall_cnt", 32'(stall_cnt), 32'd1);

        // mdu_done in S_RUN is ignored
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("stray_done_en", 32'(en_vec), 32'h1f);
        check("stray_done_fl", 32'(fl_vec), 32'h0);

        // MDU op, done 5 cycles after start, mdu_req held throughout
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mdu_start", 32'(mdu_start), 32'd1);
        check("mdu_c0_en", 32'(en_vec), 32'h03);
        check("mdu_c0_fl", 32'(fl_vec), 32'h2);
        for (int i = 1; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("mdu_c%0d_start", i), 32'(mdu_start), 32'd0);
            check($sformatf("mdu_c%0d_en", i), 32'(en_vec), 32'h03);
            check($sformatf("mdu_c%0d_fl", i), 32'(fl_vec), 32'h2);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("mdu_exit_en", 32'(en_vec), 32'h1f);
        check("mdu_exit_fl", 32'(fl_vec), 32'h0);
        check("mdu_exit_start", 32'(mdu_start), 32'd0);
        idle();
        check("mdu_run_en", 32'(en_vec), 32'h1f);
        check("mdu_stall_cnt", 32'(stall_cnt), 32'd5);

        // MDU with a 3-cycle memory stall overlapping mdu_done
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mm_start", 32'(mdu_start), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mm_c1_en", 32'(en_vec), 32'h03);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("mm_c2_en", 32'(en_vec), 32'h01);
        check("mm_c2_fl", 32'(fl_vec), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("mm_c3_en", 32'(en_vec), 32'h01);
        check("mm_c3_fl", 32'(fl_vec), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("mm_c4_en", 32'(en_vec), 32'h01);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("mm_exit_en", 32'(en_vec), 32'h1f);
        check("mm_exit_fl", 32'(fl_vec), 32'h0);
        idle();
        check("mm_run_en", 32'(en_vec), 32'h1f);
        check("mm_run_start", 32'(mdu_start), 32'd0);
        check("mm_stall_cnt", 32'(stall_cnt), 32'd5);

        // MDU timeout: no mdu_done, abort on the 8th cycle in S_MDU
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("to_start", 32'(mdu_start), 32'd1);
        for (int i = 1; i < 8; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("to_c%0d_abort", i), 32'(mdu_abort), 32'd0);
            check($sformatf("to_c%0d_en", i), 32'(en_vec), 32'h03);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("to_abort", 32'(mdu_abort), 32'd1);
        check("to_exit_en", 32'(en_vec), 32'h1f);
        idle();
        check("to_after_abort", 32'(mdu_abort), 32'd0);
        check("to_terr", 32'(timeout_err), 32'd1);
        check("to_stall_cnt", 32'(stall_cnt), 32'd8);
        check("to_resume_en", 32'(en_vec), 32'h1f);

        // Stall counter saturation: 8 + 20 stalls clamps at 15
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle();
        check("sat_stall_cnt", 32'(stall_cnt), 32'd15);
        check("terr_sticky", 32'(timeout_err), 32'd1);

        // Flush counter saturation
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle();
        check("sat_flush_cnt", 32'(flush_cnt), 32'd15);

        // Reset mid-MDU op with mdu_req still high
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mr_start", 32'(mdu_start), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mr_mdu_en", 32'(en_vec), 32'h03);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mr_rst_en", 32'(en_vec), 32'h1f);
        check("mr_rst_fl", 32'(fl_vec), 32'hf);
        check("mr_rst_start", 32'(mdu_start), 32'd0);
        idle();
        check("mr_run_en", 32'(en_vec), 32'h1f);
        check("mr_run_fl", 32'(fl_vec), 32'h0);
        check("mr_run_start", 32'(mdu_start), 32'd0);
        check("mr_stall_cnt", 32'(stall_cnt), 32'd0);
        check("mr_flush_cnt", 32'(flush_cnt), 32'd0);
        check("mr_terr", 32'(timeout_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
